// File: rtl/mig_port_arbiter_pkg.sv
// mig_arb_pkg: shared MIG user-interface constants and the output slot type.
package mig_arb_pkg;

    localparam int APP_ADDR_W = 30;
    localparam int APP_DATA_W = 256;
    localparam int APP_MASK_W = 32;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    typedef struct packed {
        logic [2:0]            cmd;
        logic [APP_ADDR_W-1:0] addr;
        logic [APP_DATA_W-1:0] wdata;
        logic                  valid;
    } slot_t;

endpackage

// File: rtl/mig_port_arbiter_if.sv
// mig_port_arbiter_if: client command/read-return ports plus the MIG app_* channels.
interface mig_port_arbiter_if #(parameter int NUM_PORTS = 2);
    import mig_arb_pkg::*;

    logic [NUM_PORTS-1:0]            c_req;
    logic [NUM_PORTS-1:0]            c_we;
    logic [NUM_PORTS*APP_ADDR_W-1:0] c_addr;
    logic [NUM_PORTS*APP_DATA_W-1:0] c_wdata;
    logic [NUM_PORTS-1:0]            c_gnt;
    logic [NUM_PORTS-1:0]            c_rd_valid;
    logic [APP_DATA_W-1:0]           c_rd_data;
    logic [APP_ADDR_W-1:0]           app_addr;
    logic [2:0]                      app_cmd;
    logic                            app_en;
    logic                            app_rdy;
    logic [APP_DATA_W-1:0]           app_wdf_data;
    logic [APP_MASK_W-1:0]           app_wdf_mask;
    logic                            app_wdf_wren;
    logic                            app_wdf_end;
    logic                            app_wdf_rdy;
    logic [APP_DATA_W-1:0]           app_rd_data;
    logic                            app_rd_data_valid;
    logic                            app_rd_data_end;

    modport master (
        input  c_req, c_we, c_addr, c_wdata, app_rdy, app_wdf_rdy,
               app_rd_data, app_rd_data_valid, app_rd_data_end,
        output c_gnt, c_rd_valid, c_rd_data, app_addr, app_cmd, app_en,
               app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );

    modport slave (
        output c_req, c_we, c_addr, c_wdata, app_rdy, app_wdf_rdy,
               app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  c_gnt, c_rd_valid, c_rd_data, app_addr, app_cmd, app_en,
               app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
    );

endinterface

// File: rtl/mig_port_arbiter_rd_tag_fifo.sv
// mig_rd_tag_fifo: in-order FIFO of issuing port indices for outstanding reads.
module mig_rd_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign data_o  = mem_q[rp_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i)
        if (do_push) mem_q[wp_q] <= data_i;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(do_push);
            rp_q  <= rp_q + AW'(do_pop);
            cnt_q <= cnt_d;
        end

endmodule

// File: rtl/mig_port_arbiter.sv
// mig_port_arbiter: round-robin sharing of one MIG user interface among client
// ports, with in-order routing of read returns back to the issuing port.
module mig_port_arbiter
    import mig_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                               ui_clk_i,
    input  logic                               ui_clk_sync_rst_i,
    input  logic                               init_calib_complete_i,
    mig_port_arbiter_if.master                 bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding_o,
    output logic                               rd_orphan_err_o
);

    localparam int PW = $clog2(NUM_PORTS);

    slot_t                 slot_q, slot_d;
    logic [PW-1:0]         last_q, last_d, win, head;
    logic [PW:0]           idx;
    logic                  found, retire, free, full, empty, push, pop, orphan_q;
    logic [NUM_PORTS-1:0]  elig, gnt, rd_valid_q, rd_valid_d;
    logic [APP_DATA_W-1:0] rd_data_q;
    logic                  unused_rd_end;

    assign retire = slot_q.valid & bus.app_rdy & (slot_q.cmd != MIG_CMD_WRITE | bus.app_wdf_rdy);
    assign free   = ~slot_q.valid | retire;

    // Search starts one past the last winner and wraps, so every port gets a turn.
    always_comb begin
        elig  = '0;
        found = 1'b0;
        win   = last_q;
        idx   = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            elig[p] = bus.c_req[p] & init_calib_complete_i & ~ui_clk_sync_rst_i & free
                      & (bus.c_we[p] | ~full);
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = {1'b0, last_q} + (PW+1)'(i);
            idx = idx >= (PW+1)'(NUM_PORTS) ? idx - (PW+1)'(NUM_PORTS) : idx;
            if (!found && elig[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    assign gnt        = found ? NUM_PORTS'(1) << win : '0;
    assign push       = found & ~bus.c_we[win];
    assign pop        = bus.app_rd_data_valid & ~empty;
    assign last_d     = found ? win : last_q;
    assign rd_valid_d = pop ? NUM_PORTS'(1) << head : '0;
    assign slot_d     = found ? '{cmd:   bus.c_we[win] ? MIG_CMD_WRITE : MIG_CMD_READ,
                                  addr:  bus.c_addr[win*APP_ADDR_W +: APP_ADDR_W],
                                  wdata: bus.c_wdata[win*APP_DATA_W +: APP_DATA_W],
                                  valid: 1'b1}
                              : '{cmd: slot_q.cmd, addr: slot_q.addr, wdata: slot_q.wdata,
                                  valid: slot_q.valid & ~retire};

    always_ff @(posedge ui_clk_i or posedge ui_clk_sync_rst_i)
        if (ui_clk_sync_rst_i) begin
            slot_q     <= '0;
            last_q     <= PW'(NUM_PORTS-1);
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            orphan_q   <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= pop ? bus.app_rd_data : rd_data_q;
            orphan_q   <= orphan_q | (bus.app_rd_data_valid & empty);
        end

    mig_rd_tag_fifo #(.W(PW), .DEPTH(MAX_OUTSTANDING)) u_rd_tag_fifo (
        .clk_i   (ui_clk_i),
        .rst_i   (ui_clk_sync_rst_i),
        .push_i  (push),
        .data_i  (win),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (rd_outstanding_o)
    );

    assign bus.c_gnt        = gnt;
    assign bus.c_rd_valid   = rd_valid_q;
    assign bus.c_rd_data    = rd_data_q;
    assign bus.app_en       = slot_q.valid;
    assign bus.app_cmd      = slot_q.cmd;
    assign bus.app_addr     = slot_q.addr;
    assign bus.app_wdf_data = slot_q.wdata;
    assign bus.app_wdf_mask = '0;
    assign bus.app_wdf_wren = slot_q.valid & slot_q.cmd == MIG_CMD_WRITE;
    assign bus.app_wdf_end  = slot_q.valid & slot_q.cmd == MIG_CMD_WRITE;
    assign rd_orphan_err_o  = orphan_q;
    assign unused_rd_end    = bus.app_rd_data_end;

endmodule

// File: tb/tb_mig_port_arbiter.sv
// tb_mig_port_arbiter: directed checks of gating, round-robin, backpressure,
// read routing, full tag FIFO, orphan beats and asynchronous reset.
module tb_mig_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       calib;
    logic [4:0] outstanding;
    logic       orphan;
    int         total = 0;
    int         bad   = 0;

    localparam logic [255:0] WD0 = {8{32'h0000_00A0}};
    localparam logic [255:0] WD1 = {8{32'h0000_00B1}};
    localparam logic [255:0] AA  = {32{8'hAA}};
    localparam logic [255:0] BB  = {32{8'hBB}};
    localparam logic [255:0] CC  = {32{8'hCC}};

    always #5 clk = ~clk;

    mig_port_arbiter_if #(.NUM_PORTS(2)) bus ();

    mig_port_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(16)) dut (
        .ui_clk_i              (clk),
        .ui_clk_sync_rst_i     (rst),
        .init_calib_complete_i (calib),
        .bus                   (bus),
        .rd_outstanding_o      (outstanding),
        .rd_orphan_err_o       (orphan)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        calib = 1'b0;
        bus.c_req = '0;
        bus.c_we = '0;
        bus.c_addr = '0;
        bus.c_wdata = '0;
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        bus.app_rd_data = '0;
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data_end = 1'b0;
        tick(); bus.c_req = 2'b11; #4;
        chk("rst_gnt", bus.c_gnt, 0);
        chk("rst_app_en", bus.app_en, 0);
        chk("rst_wren", bus.app_wdf_wren, 0);
        chk("rst_wend", bus.app_wdf_end, 0);
        chk("rst_cmd", bus.app_cmd, 0);
        chk("rst_addr", bus.app_addr, 0);
        chk("rst_wdata", bus.app_wdf_data, 0);
        chk("rst_mask", bus.app_wdf_mask, 0);
        chk("rst_rd_valid", bus.c_rd_valid, 0);
        chk("rst_rd_data", bus.c_rd_data, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_orphan", orphan, 0);
        tick(); rst = 1'b0; bus.c_we = 2'b11;
        bus.c_addr = {30'h200, 30'h100}; bus.c_wdata = {WD1, WD0}; #4;
        chk("calib_gnt0", bus.c_gnt, 0);
        tick(); #4;
        chk("calib_app_en", bus.app_en, 0);
        chk("calib_gnt1", bus.c_gnt, 0);
        tick(); calib = 1'b1; #4;
        chk("calib_rise_gnt", bus.c_gnt, 2'b01);
        tick(); #4;
        chk("rr_en", bus.app_en, 1);
        chk("rr_addr0", bus.app_addr, 30'h100);
        chk("rr_cmd", bus.app_cmd, 3'b000);
        chk("rr_wren", bus.app_wdf_wren, 1);
        chk("rr_wdata0", bus.app_wdf_data, WD0);
        chk("rr_gnt1", bus.c_gnt, 2'b10);
        tick(); #4;
        chk("rr_addr1", bus.app_addr, 30'h200);
        chk("rr_wdata1", bus.app_wdf_data, WD1);
        chk("rr_gnt2", bus.c_gnt, 2'b01);
        tick(); #4;
        chk("rr_addr2", bus.app_addr, 30'h100);
        chk("rr_gnt3", bus.c_gnt, 2'b10);
        for (int i = 0; i < 3; i++) begin
            tick(); bus.app_wdf_rdy = 1'b0; #4;
            chk("bp_gnt", bus.c_gnt, 0);
            chk("bp_en", bus.app_en, 1);
            chk("bp_wren", bus.app_wdf_wren, 1);
            chk("bp_addr", bus.app_addr, 30'h200);
        end
        tick(); bus.app_wdf_rdy = 1'b1; #4;
        chk("bp_release_gnt", bus.c_gnt, 2'b01);
        chk("bp_release_addr", bus.app_addr, 30'h200);
        tick(); bus.c_req = 2'b00; #4;
        chk("bp_next_addr", bus.app_addr, 30'h100);
        chk("idle_gnt", bus.c_gnt, 0);
        tick(); #4;
        chk("idle_en", bus.app_en, 0);
        tick(); bus.c_req = 2'b10; bus.c_we = 2'b00; bus.c_addr = {30'h10, 30'h100}; #4;
        chk("rd_gnt_p1", bus.c_gnt, 2'b10);
        tick(); bus.c_req = 2'b01; bus.c_addr = {30'h10, 30'h20}; #4;
        chk("rd_gnt_p0", bus.c_gnt, 2'b01);
        chk("rd_cmd", bus.app_cmd, 3'b001);
        chk("rd_addr_p1", bus.app_addr, 30'h10);
        chk("rd_wren", bus.app_wdf_wren, 0);
        chk("rd_out1", outstanding, 1);
        tick(); bus.c_req = 2'b00; #4;
        chk("rd_addr_p0", bus.app_addr, 30'h20);
        chk("rd_out2", outstanding, 2);
        tick(); bus.app_rd_data_valid = 1'b1; bus.app_rd_data = AA; #4;
        chk("rd_lat", bus.c_rd_valid, 0);
        tick(); bus.app_rd_data = BB; #4;
        chk("rd_valid_p1", bus.c_rd_valid, 2'b10);
        chk("rd_data_aa", bus.c_rd_data, AA);
        chk("rd_out_pop1", outstanding, 1);
        tick(); bus.app_rd_data_valid = 1'b0; #4;
        chk("rd_valid_p0", bus.c_rd_valid, 2'b01);
        chk("rd_data_bb", bus.c_rd_data, BB);
        chk("rd_out_pop2", outstanding, 0);
        tick(); #4;
        chk("rd_valid_idle", bus.c_rd_valid, 0);
        chk("rd_no_orphan", orphan, 0);
        for (int i = 0; i < 16; i++) begin
            tick(); bus.c_req = 2'b10; bus.c_addr = {30'(i), 30'h20}; #4;
            chk("fill_gnt", bus.c_gnt, 2'b10);
        end
        tick(); #4;
        chk("full_out", outstanding, 16);
        chk("full_blocked", bus.c_gnt, 0);
        tick(); bus.c_req = 2'b11; bus.c_we = 2'b01; #4;
        chk("full_write_gnt", bus.c_gnt, 2'b01);
        tick(); bus.c_req = 2'b10; bus.app_rd_data_valid = 1'b1; bus.app_rd_data = CC; #4;
        chk("full_pop_blocked", bus.c_gnt, 0);
        chk("full_write_cmd", bus.app_cmd, 3'b000);
        tick(); bus.app_rd_data_valid = 1'b0; #4;
        chk("resume_gnt", bus.c_gnt, 2'b10);
        chk("resume_rd_valid", bus.c_rd_valid, 2'b10);
        chk("resume_out", outstanding, 15);
        tick(); #4;
        chk("refull_out", outstanding, 16);
        chk("refull_en", bus.app_en, 1);
        chk("refull_gnt", bus.c_gnt, 0);
        rst = 1'b1; #1;
        chk("arst_en", bus.app_en, 0);
        chk("arst_out", outstanding, 0);
        chk("arst_gnt", bus.c_gnt, 0);
        chk("arst_addr", bus.app_addr, 0);
        chk("arst_wren", bus.app_wdf_wren, 0);
        chk("arst_rd_valid", bus.c_rd_valid, 0);
        chk("arst_rd_data", bus.c_rd_data, 0);
        tick(); rst = 1'b0; bus.c_req = 2'b00; bus.app_rd_data_valid = 1'b1; #4;
        chk("orphan_pending", orphan, 0);
        tick(); bus.app_rd_data_valid = 1'b0; #4;
        chk("orphan_set", orphan, 1);
        chk("orphan_rd_valid", bus.c_rd_valid, 0);
        chk("orphan_out", outstanding, 0);
        tick(); bus.c_req = 2'b11; bus.c_we = 2'b11; #4;
        chk("orphan_sticky", orphan, 1);
        chk("post_rst_gnt", bus.c_gnt, 2'b01);
        tick(); bus.c_req = 2'b00; #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mig_port_arbiter.md
# mig_port_arbiter

Round-robin arbiter sharing the single MIG user interface (app_* command, write-data and read-data channels) among NUM_PORTS client ports. It issues each granted command and its write data together from a one-entry output slot. It tracks outstanding reads in an in-order tag FIFO and routes each returning read beat to the port that issued it. It sits between the client engines and the MIG (or its simulation model) in the ui_clk domain.

## Interface
- NUM_PORTS, 2: number of client ports (2..8).
- MAX_OUTSTANDING, 16: read tag FIFO depth (power of two).
- ui_clk  in  1  the only clock; MIG user-interface clock.
- ui_clk_sync_rst  in  1  reset, asynchronous, active-high.
- init_calib_complete  in  1  grants are inhibited while low.
- c_req  in  NUM_PORTS  per-port command request; held until granted.
- c_we  in  NUM_PORTS  per-port command type: 1 = write, 0 = read.
- c_addr  in  NUM_PORTS*30  per-port app address; port p occupies bits [30p+29:30p].
- c_wdata  in  NUM_PORTS*256  per-port write data; port p occupies bits [256p+255:256p].
- c_gnt  out  NUM_PORTS  one-hot grant; combinational; request accepted this cycle.
- c_rd_valid  out  NUM_PORTS  one-hot read return strobe.
- c_rd_data  out  256  read return data, shared by all ports; qualified by c_rd_valid.
- app_addr, app_cmd, app_en  out  30, 3, 1  MIG command channel.
- app_rdy  in  1  MIG command ready.
- app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end  out  256, 32, 1, 1  MIG write-data channel.
- app_wdf_rdy  in  1  MIG write-data ready.
- app_rd_data, app_rd_data_valid, app_rd_data_end  in  256, 1, 1  MIG read-data channel.
- rd_outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy.
- rd_orphan_err  out  1  sticky flag: a read beat returned with no tag outstanding.

## Operation
- Output slot: one register holding cmd, addr, wdata and a valid bit.
  - app_en = slot valid.
  - app_wdf_wren = app_wdf_end = slot valid and slot is a write.
  - app_wdf_mask is always 0; app_cmd is 000 for write, 001 for read.
- Slot retire: slot valid and app_rdy, plus app_wdf_rdy when the slot holds a write. If app_rdy is high but app_wdf_rdy is low, the write is held: app_en and app_wdf_wren both stay asserted.
- Slot is free when it is not valid or it retires this cycle.
- Eligibility: port p is eligible when c_req[p] is high, init_calib_complete is high, reset is deasserted, the slot is free, and either c_we[p] is 1 or the tag FIFO is not full.
- Arbitration: round-robin. The search starts at last_grant+1 and wraps modulo NUM_PORTS; the first eligible port wins. The winner's c_gnt is high; its command loads the slot at the clock edge, and last_grant is updated to the winner.
- Read tags:
  - Push the granted port index when a read is granted, not when it is issued.
  - Pop on app_rd_data_valid. The popped index selects c_rd_valid; app_rd_data is registered into c_rd_data.
  - MIG returns reads in order, so no reordering is needed.
- Full FIFO: reads are blocked even if a pop happens in the same cycle. Writes continue to be granted.
- app_rd_data_valid while the FIFO is empty: the beat is dropped, rd_orphan_err is set, and c_rd_valid stays 0.
- Reset (asynchronous, including mid-operation):
  - Slot is invalidated; the FIFO is emptied; last_grant = NUM_PORTS-1, so port 0 wins first.
  - Reads in flight at the time of reset are discarded.
- Reset values: app_en, app_wdf_wren, app_wdf_end, c_rd_valid, rd_orphan_err = 0; app_cmd, app_addr, app_wdf_data, app_wdf_mask, c_rd_data = 0; rd_outstanding = 0; c_gnt = 0.

## Timing
- Grant to app_en: c_gnt in cycle t, app_en in cycle t+1.
- Back-to-back: if app_rdy is high in t+1, the next grant may occur in t+1. Sustained throughput is one command per cycle.
- Read return: app_rd_data_valid in cycle r gives c_rd_valid/c_rd_data in cycle r+1 (one-cycle latency).
- Clients must drop or change c_req the cycle after c_gnt; c_req held high is treated as a new request.
- rd_outstanding updates one cycle after a push or pop; a simultaneous push and pop leaves it unchanged.

## Structure
- Package mig_arb_pkg:
  - MIG_CMD_WRITE = 3'b000, MIG_CMD_READ = 3'b001.
  - APP_ADDR_W = 30, APP_DATA_W = 256, APP_MASK_W = 32.
  - Slot struct typedef: cmd, addr, wdata, valid.
- Sub-module mig_rd_tag_fifo: synchronous FIFO of port indices, width $clog2(NUM_PORTS), depth MAX_OUTSTANDING, with full, empty and count outputs and the same asynchronous reset.

## Test plan
- Calibration gate: init_calib_complete=0 and c_req=2'b11 → no c_gnt and app_en=0; calibration rises → c_gnt=2'b01 next cycle.
- Round-robin: both ports request writes continuously with app_rdy=app_wdf_rdy=1 → grants alternate 01,10,01,…; the app_addr sequence matches each port's c_addr.
- Write backpressure: app_rdy=1, app_wdf_rdy=0 for 3 cycles → slot held, no new grants; app_wdf_rdy=1 → slot retires that cycle and a grant occurs the same cycle.
- Read routing: port1 reads 0x10, then port0 reads 0x20; the model returns 0xAA… then 0xBB… → c_rd_valid=10 with 0xAA…, then 01 with 0xBB…, one cycle after each app_rd_data_valid.
- FIFO full: 16 reads granted with no returns → port read requests blocked, rd_outstanding=16, a write from the other port still granted; one return → reads resume the next cycle.
- Faults: app_rd_data_valid with the FIFO empty → rd_orphan_err=1 and stays set; async reset asserted mid-burst → all outputs take their reset values immediately and rd_outstanding=0.
